gonso_wb_initiator: RTL

//  Single-transfer Wishbone classic initiator (master): the requesting end of the bus the gonso

---
 rtl/gonso_wb_initiator.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gonso_wb_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gonso_wb_initiator : single-transfer Wishbone classic initiator with timeout
// Revision 1.0
// ---------------------------------------------------------------------------
module gonso_wb_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               cyc_nxt, we_nxt, ready_nxt, rvalid_nxt, rerr_nxt;
  logic [ADDR_W-1:0]  adr_nxt;
  logic [DATA_W-1:0]  dat_nxt, rdata_nxt;
  logic [SEL_W-1:0]   sel_nxt;

  // Strobe mirrors cycle; both come straight from the same flop.
  assign wbm_stb_o = wbm_cyc_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd_ready <= ready_nxt;
      rsp_valid <= rvalid_nxt;
      rsp_rdata <= rdata_nxt;
      rsp_err   <= rerr_nxt;
      wbm_cyc_o <= cyc_nxt;
      wbm_we_o  <= we_nxt;
      wbm_adr_o <= adr_nxt;
      wbm_dat_o <= dat_nxt;
      wbm_sel_o <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ready_nxt  = cmd_ready;
    rvalid_nxt = rsp_valid;
    rdata_nxt  = rsp_rdata;
    rerr_nxt   = rsp_err;
    cyc_nxt    = wbm_cyc_o;
    we_nxt     = wbm_we_o;
    adr_nxt    = wbm_adr_o;
    dat_nxt    = wbm_dat_o;
    sel_nxt    = wbm_sel_o;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          we_nxt    = cmd_we;
          adr_nxt   = cmd_addr;
          dat_nxt   = cmd_wdata;
          sel_nxt   = cmd_sel;
          cyc_nxt   = 1'b1;
          cnt_nxt   = '0;
          ready_nxt = 1'b0;
          state_nxt = BUS;
        end
      end
      BUS: begin
        // An ack on the final counted edge still completes normally.
        if (wbm_ack_i) begin
          cyc_nxt    = 1'b0;
          rdata_nxt  = wbm_we_o ? '0 : wbm_dat_i;
          rerr_nxt   = 1'b0;
          rvalid_nxt = 1'b1;
          state_nxt  = RESP;
        end else if (cnt == CNT_LAST) begin
          cyc_nxt    = 1'b0;
          rdata_nxt  = '0;
          rerr_nxt   = 1'b1;
          rvalid_nxt = 1'b1;
          state_nxt  = RESP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rvalid_nxt = 1'b0;
          ready_nxt  = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
